// File: rtl/tilt_steer_ctrl.sv
// rtl/tilt_steer_ctrl.sv - accelerometer tilt to debounced, hysteresis-filtered snake steering
module tilt_steer_ctrl #(
    parameter int AXIS_W     = 5,
    parameter int SAMPLE_DIV = 100000,
    parameter int CAL_LOG2   = 4,
    parameter int THRESH     = 4,
    parameter int PERSIST    = 3,
    parameter int DEBOUNCE   = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*AXIS_W-1:0]   acl_data,
    input  logic                  button,
    input  logic                  step,
    output logic [1:0]            dir,
    output logic                  dir_changed,
    output logic                  paused,
    output logic                  calibrating
);
    localparam int TICK_W = $clog2(SAMPLE_DIV);
    localparam int ACC_W  = AXIS_W + CAL_LOG2;
    localparam int D_W    = AXIS_W + 1;
    localparam int P_W    = $clog2(PERSIST + 1);
    localparam int DB_W   = $clog2(DEBOUNCE);

    typedef enum logic [1:0] {CALIB, RUN, PAUSE} state_t;
    state_t state, state_next;

    logic signed [AXIS_W-1:0] ax_x, ax_y, off_x, off_y;
    logic                     unused_z;
    assign ax_x     = acl_data[3*AXIS_W-1 -: AXIS_W];
    assign ax_y     = acl_data[2*AXIS_W-1 -: AXIS_W];
    assign unused_z = ^acl_data[AXIS_W-1:0];

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    assign tick = (tick_cnt == TICK_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + 1'b1;
    end

    // Calibration: running sums of X/Y, averaged by arithmetic shift
    logic signed [ACC_W-1:0] acc_x, acc_y, acc_x_next, acc_y_next;
    logic [CAL_LOG2-1:0]     cal_cnt;
    logic                    cal_done;
    assign acc_x_next = acc_x + ACC_W'(ax_x);
    assign acc_y_next = acc_y + ACC_W'(ax_y);
    assign cal_done   = (state == CALIB) && tick && (cal_cnt == '1);

    logic signed [D_W-1:0] dx, dy;
    logic [D_W-1:0]        mag_x, mag_y;
    assign dx    = D_W'(ax_x) - D_W'(off_x);
    assign dy    = D_W'(ax_y) - D_W'(off_y);
    assign mag_x = dx[D_W-1] ? -dx : dx;
    assign mag_y = dy[D_W-1] ? -dy : dy;

    logic       cand_valid;
    logic [1:0] cand_dir;
    always_comb begin
        cand_valid = 1'b0;
        cand_dir   = 2'b00;
        if ((mag_x != mag_y) && ((mag_x >= D_W'(THRESH)) || (mag_y >= D_W'(THRESH)))) begin
            cand_valid = 1'b1;
            if (mag_x > mag_y) cand_dir = dx[D_W-1] ? 2'b11 : 2'b01;
            else               cand_dir = dy[D_W-1] ? 2'b10 : 2'b00;
        end
    end

    logic [P_W-1:0] p_cnt, p_next;
    logic           last_valid;
    logic [1:0]     last_dir;
    logic [1:0]     pending;
    always_comb begin
        p_next = p_cnt;
        if (!cand_valid)
            p_next = '0;
        else if (last_valid && (last_dir == cand_dir))
            p_next = (p_cnt == P_W'(PERSIST)) ? p_cnt : p_cnt + 1'b1;
        else
            p_next = P_W'(1);
    end

    // Button: two-flop synchroniser, then level accepted after DEBOUNCE stable cycles
    logic            btn_s1, btn_s2, btn_lvl, btn_rise;
    logic [DB_W-1:0] db_cnt;
    assign btn_rise = btn_s2 && !btn_lvl && (db_cnt == DB_W'(DEBOUNCE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            btn_lvl <= 1'b0;
            db_cnt  <= '0;
        end else begin
            btn_s1 <= button;
            btn_s2 <= btn_s1;
            if (btn_s2 == btn_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
                btn_lvl <= btn_s2;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    logic run_active, commit;
    assign run_active = (state == RUN) && !btn_rise;
    assign commit     = run_active && step && (pending != dir) && (pending != (dir ^ 2'b10));

    always_ff @(posedge clk) begin
        if (rst) state <= CALIB;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            CALIB:   if (cal_done) state_next = RUN;
            RUN:     if (btn_rise) state_next = PAUSE;
            PAUSE:   if (btn_rise) state_next = RUN;
            default: state_next = CALIB;
        endcase
    end

    assign paused      = (state == PAUSE);
    assign calibrating = (state == CALIB);

    always_ff @(posedge clk) begin
        if (rst) begin
            dir         <= 2'b01;
            pending     <= 2'b01;
            dir_changed <= 1'b0;
            off_x       <= '0;
            off_y       <= '0;
            acc_x       <= '0;
            acc_y       <= '0;
            cal_cnt     <= '0;
            p_cnt       <= '0;
            last_valid  <= 1'b0;
            last_dir    <= 2'b00;
        end else begin
            dir_changed <= commit;
            if (commit) dir <= pending;
            if (cal_done) begin
                off_x   <= AXIS_W'(acc_x_next >>> CAL_LOG2);
                off_y   <= AXIS_W'(acc_y_next >>> CAL_LOG2);
                acc_x   <= '0;
                acc_y   <= '0;
                cal_cnt <= '0;
            end else if ((state == CALIB) && tick) begin
                acc_x   <= acc_x_next;
                acc_y   <= acc_y_next;
                cal_cnt <= cal_cnt + 1'b1;
            end
            if (run_active && tick) begin
                p_cnt      <= p_next;
                last_valid <= cand_valid;
                last_dir   <= cand_dir;
                if (p_next == P_W'(PERSIST)) pending <= cand_dir;
            end else if (state != CALIB && !run_active) begin
                p_cnt      <= '0;
                last_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tilt_steer_ctrl.sv
// tb/tb_tilt_steer_ctrl.sv - scoreboard bench for tilt_steer_ctrl
module tb_tilt_steer_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] acl_data = '0;
    logic        button = 1'b0;
    logic        step = 1'b0;
    logic [1:0]  dir;
    logic        dir_changed, paused, calibrating;

    int total = 0;
    int bad   = 0;

    logic [1:0] chg_q[$];
    logic [3:0] stat_q[$];
    string      name_q[$];

    tilt_steer_ctrl #(
        .AXIS_W(5), .SAMPLE_DIV(4), .CAL_LOG2(2),
        .THRESH(4), .PERSIST(3), .DEBOUNCE(8)
    ) dut (
        .clk(clk), .rst(rst), .acl_data(acl_data), .button(button), .step(step),
        .dir(dir), .dir_changed(dir_changed), .paused(paused), .calibrating(calibrating)
    );

    always #5 clk = ~clk;

    // Monitor: checks every dir_changed pulse and any queued status expectation
    initial begin
        logic [1:0] e_dir;
        logic [3:0] e_st;
        string      nm;
        forever begin
            @(negedge clk);
            if (dir_changed) begin
                total++;
                if (chg_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_pulse: dir_changed=1 dir=%b, required no pulse", dir);
                end else begin
                    e_dir = chg_q.pop_front();
                    if (dir !== e_dir) begin
                        bad++;
                        $display("FAIL pulse_dir: dir=%b, required %b", dir, e_dir);
                    end
                end
            end
            if (stat_q.size() > 0) begin
                e_st = stat_q.pop_front();
                nm   = name_q.pop_front();
                total++;
                if ({dir, paused, calibrating} !== e_st) begin
                    bad++;
                    $display("FAIL %s: dir/paused/cal=%b/%b/%b, required %b/%b/%b",
                             nm, dir, paused, calibrating, e_st[3:2], e_st[1], e_st[0]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_xy(input int x, input int y);
        acl_data = {5'(x), 5'(y), 5'd0};
    endtask

    task automatic expect_stat(input string nm, input logic [1:0] d, input logic p, input logic c);
        stat_q.push_back({d, p, c});
        name_q.push_back(nm);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic press(input int n);
        button = 1'b1;
        cyc(n);
        button = 1'b0;
    endtask

    task automatic calib_check(input string tag);
        cyc(15);
        expect_stat({tag, "_cal_high"}, 2'b01, 1'b0, 1'b1);
        cyc(1);
        expect_stat({tag, "_cal_low"}, 2'b01, 1'b0, 1'b0);
    endtask

    initial begin
        set_xy(2, -1);
        cyc(2);
        expect_stat("reset_state", 2'b01, 1'b0, 1'b1);
        cyc(1);
        rst = 1'b0;

        // Calibration with offsets 2/-1, then neutral input gives no turn
        calib_check("calib1");
        pulse_step();
        expect_stat("neutral_step", 2'b01, 1'b0, 1'b0);

        // Reversal: left while heading right is refused
        set_xy(-6, -1); cyc(12);
        set_xy(2, -1); pulse_step();
        expect_stat("reversal_block", 2'b01, 1'b0, 1'b0);

        // Turn up
        set_xy(2, 7); cyc(12);
        set_xy(2, -1);
        chg_q.push_back(2'b00);
        pulse_step();
        expect_stat("turn_up", 2'b00, 1'b0, 1'b0);

        // Turn right to set up the persistence case
        set_xy(10, -1); cyc(12);
        set_xy(2, -1);
        chg_q.push_back(2'b01);
        pulse_step();
        expect_stat("turn_right", 2'b01, 1'b0, 1'b0);

        // Persistence broken by a neutral tick
        set_xy(2, 7); cyc(8);
        set_xy(2, -1); cyc(4);
        set_xy(2, 7); cyc(8);
        pulse_step();
        expect_stat("persist_short", 2'b01, 1'b0, 1'b0);
        set_xy(2, -1);
        chg_q.push_back(2'b00);
        pulse_step();
        expect_stat("persist_done", 2'b00, 1'b0, 1'b0);

        // Dead zone, then tie
        set_xy(5, -1); cyc(8);
        set_xy(8, -7); cyc(12);
        pulse_step();
        expect_stat("deadzone_tie", 2'b00, 1'b0, 1'b0);

        // Pause toggle
        set_xy(2, -1);
        press(10);
        expect_stat("pause_on", 2'b00, 1'b1, 1'b0);
        set_xy(10, -1);
        pulse_step(); pulse_step();
        expect_stat("paused_steps", 2'b00, 1'b1, 1'b0);
        cyc(20);
        set_xy(2, -1);
        press(10);
        expect_stat("pause_off", 2'b00, 1'b0, 1'b0);
        cyc(20);
        pulse_step();
        expect_stat("resume_pending_held", 2'b00, 1'b0, 1'b0);
        press(5);
        cyc(20);
        expect_stat("glitch_ignored", 2'b00, 1'b0, 1'b0);
        press(10);
        expect_stat("pause_again", 2'b00, 1'b1, 1'b0);
        cyc(3);

        // Reset mid-pause, then reset mid-calibration with junk data
        set_xy(15, -16);
        do_reset();
        expect_stat("reset_in_pause", 2'b01, 1'b0, 1'b1);
        cyc(8);
        set_xy(6, 3);
        do_reset();
        calib_check("calib2");
        cyc(12);
        pulse_step();
        expect_stat("new_offset_neutral", 2'b01, 1'b0, 1'b0);
        set_xy(6, 11); cyc(12);
        set_xy(6, 3);
        chg_q.push_back(2'b00);
        pulse_step();
        expect_stat("new_offset_turn", 2'b00, 1'b0, 1'b0);

        cyc(4);
        total++;
        if (chg_q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulse: outstanding=%0d, required 0", chg_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tilt_steer_ctrl.md
Name: tilt_steer_ctrl

Overview:
Parametrised successor to the fixed accelerometer-to-game input path. It converts packed X/Y/Z accelerometer samples from the SPI master into a debounced, hysteresis-filtered steering direction for the snake game, and commits that direction on each game step strobe. It adds power-on zero-offset calibration, a dead zone, a tilt persistence filter, a no-reversal rule and a debounced pause toggle on the centre button. It sits between spi_master/BtnC and snake_game, in the CLK100MHZ domain.

Parameters:
AXIS_W, 5, bits per axis in acl_data; each axis is two's complement signed.
SAMPLE_DIV, 100000, clk cycles per sample tick; must be >= 2.
CAL_LOG2, 4, log2 of the number of samples averaged during calibration.
THRESH, 4, dead-zone magnitude; tilts below this produce no candidate.
PERSIST, 3, consecutive ticks a candidate must hold before it becomes pending.
DEBOUNCE, 1000000, clk cycles the synchronised button must be stable to register.

Ports:
clk  in  1  system clock (CLK100MHZ).
rst  in  1  reset; synchronous, active-high.
acl_data  in  3*AXIS_W  packed {X,Y,Z}; X is the MSB field. Z is ignored.
button  in  1  raw centre button (BtnC), asynchronous.
step  in  1  one-cycle game-advance strobe from snake_game.
dir  out  2  committed direction: 00 up, 01 right, 10 down, 11 left.
dir_changed  out  1  one-cycle pulse when dir changes.
paused  out  1  high while in PAUSE.
calibrating  out  1  high while in CALIB.

Behaviour:
- Reset values: dir=01, pending=01, dir_changed=0, paused=0, calibrating=1, offsets=0, tick counter=0, persistence counter=0, state=CALIB. A reset in any state, including mid-calibration, restarts calibration from zero.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. tick=1 in the cycle where count==SAMPLE_DIV-1. The counter runs in all states.
- States:
  - CALIB: each tick adds X and Y into signed accumulators of width AXIS_W+CAL_LOG2. After 2^CAL_LOG2 ticks: offx=accx>>>CAL_LOG2 and offy=accy>>>CAL_LOG2 (arithmetic shift). The block then goes to RUN and calibrating falls on the next cycle. Button and step are ignored in CALIB.
  - RUN: each tick computes dx=X-offx and dy=Y-offy, sign-extended to AXIS_W+1 bits (no overflow possible). Take the magnitudes |dx| and |dy|.
    - Candidate is none if max(|dx|,|dy|) < THRESH, or if |dx|==|dy|.
    - Otherwise the larger axis sets the candidate: dx>0 right, dx<0 left, dy>0 up, dy<0 down.
  - PAUSE: sampling, persistence and step are all ignored. The persistence counter is held at 0. dir and pending are held.
- Persistence filter (RUN, per tick):
  - Candidate none: counter cleared.
  - Candidate equals the last candidate: counter increments, saturating at PERSIST.
  - New non-none candidate: counter set to 1.
  - When the counter reaches PERSIST, pending is loaded with the candidate.
- Commit (RUN, step=1):
  - If pending != dir and pending is not the opposite of dir (opposite = dir XOR 2'b10), dir is loaded with pending in that cycle and dir_changed=1 in the following cycle.
  - Otherwise dir is unchanged and dir_changed=0.
  - step uses the pending value registered before the cycle, so a same-cycle tick update is not seen until the next step.
- Button: 2-flop synchroniser, then a stability counter. The debounced level updates after DEBOUNCE consecutive cycles of a stable synchronised value. A debounced rising edge toggles RUN<->PAUSE, and paused follows on the next cycle.
- Priority in one cycle: rst > button edge > step > tick. A step in the same cycle as a pause edge is dropped.
- dir_changed is never high for two consecutive cycles unless step is asserted on consecutive cycles with valid changes.

Test Plan:
All scenarios use AXIS_W=5, SAMPLE_DIV=4, CAL_LOG2=2, THRESH=4, PERSIST=3, DEBOUNCE=8.
1. Calibration: hold X=2, Y=-1 from reset -> calibrating=1 for 4 ticks (16 cycles), then 0. Offsets are 2 and -1. The same input then gives candidate none, and a step leaves dir=01 with no pulse.
2. Turn: after calibration, set Y=7 (dy=8) for 3 ticks, then pulse step -> dir=00, dir_changed=1 for exactly one cycle.
3. Reversal block: dir=01, set X=-6 (dx=-8) for 3 ticks, pending=11, pulse step -> dir stays 01, dir_changed=0.
4. Persistence: Y=7 for 2 ticks, then Y=-1 for 1 tick, then Y=7 for 2 ticks, then step -> dir unchanged. One more Y=7 tick, then step -> dir=00.
5. Dead zone and tie: dx=3, dy=0 -> no candidate. dx=6, dy=-6 -> no candidate. Over 5 ticks plus a step, dir is unchanged.
6. Pause: button high for 10 cycles -> paused=1. Strong tilts and steps while paused leave dir unchanged. A second press of 10 cycles -> paused=0. A 5-cycle glitch causes no toggle. rst asserted mid-pause -> CALIB, paused=0.
